bfp_packer: RTL and testbench
=============================

BFP_PACKER -- requirements
Module: bfp_packer

Interface
REQ-001 Parameter LANES, default 16, number of elements per block; fixed to the fmac lane count.
REQ-002 Parameter MAG_W, default 3, mantissa magnitude bits per lane, excluding the sign bit.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_valid  in  1  input element valid.
REQ-006 o_ready  out  1  block can accept an element this cycle.
REQ-007 i_data  in  16  bf16 element: [15] sign, [14:7] exponent, [6:0] fraction.
REQ-008 i_flush  in  1  close the partial block; unfilled lanes are zero.
REQ-009 o_valid  out  1  packed block valid.
REQ-010 i_ready  in  1  downstream (fmac feeder) accepts the block.
REQ-011 o_E  out  8  shared block exponent.
REQ-012 o_M  out  LANES*(MAG_W+1)  lane k at bits [k*4+:4], formatted {sign, mag[2:0]}; bit 3 is the sign, as consumed by fmac.

Function
REQ-013 The block SHALL have three states: FILL, ALIGN and OUT.
REQ-014 In FILL, o_ready SHALL be 1; in ALIGN and OUT, o_ready SHALL be 0.
REQ-015 An element is accepted when i_valid && o_ready; accepted element n (n = 0..15, count order) SHALL be stored in lane n.
REQ-016 Per block, a 4-bit element counter SHALL increment per accept, and a running max of the element exponents SHALL be kept.
REQ-017 When the 16th element is accepted, the next state SHALL be ALIGN and the counter SHALL wrap to 0.
REQ-018 i_flush in FILL with count > 0 SHALL move the block to ALIGN; unfilled lanes are treated as +0 (exponent 0).
REQ-019 If i_flush coincides with an accepted element, that element SHALL be included before the flush takes effect.
REQ-020 i_flush with count = 0 and no accept SHALL be ignored; i_flush outside FILL SHALL be ignored.
REQ-021 In ALIGN, the module SHALL register o_E = max exponent and compute all lanes in one cycle, then enter OUT.
REQ-022 Lane alignment: shift s = o_E - E_lane; v = {1, frac[6:5]} >> s; mag = v[2:0]; s >= 3 gives mag = 0.
REQ-023 A lane with E_lane = 0 (zero or subnormal) SHALL have mag = 0.
REQ-024 The sign bit SHALL be passed unchanged, including on zero lanes.
REQ-025 E_lane = 255 (Inf/NaN) SHALL be handled by the same arithmetic; o_E = 255 and no special flag is produced.
REQ-026 In OUT, o_valid SHALL be 1 and o_E/o_M SHALL hold stable until i_ready.
REQ-027 o_valid && i_ready SHALL return the block to FILL next cycle, with max cleared and o_valid = 0.
REQ-028 Latency: 16th accept at edge N → o_valid high from edge N+2.
REQ-029 Minimum period per full block is 18 cycles.

Reset
REQ-030 i_reset high at an edge SHALL set state FILL, counter 0, max exponent 0, o_valid 0, o_E 0 and o_M 0.
REQ-031 Reset SHALL take priority over all inputs.
REQ-032 Reset mid-FILL or in OUT SHALL discard the partial or pending block with no output produced.
REQ-033 o_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-034 With macro BFP_ROUND_EN defined: v4 = {1, frac[6:4]} >> s; mag = v4[3:1] + v4[0], saturated at 7 (round half up).
REQ-035 Without BFP_ROUND_EN, truncation per REQ-022 SHALL apply; the interface and latency SHALL be identical in both builds.

Verification
REQ-036 16x 0x3F80 (1.0) → o_E = 127, every lane = 4'b0100, o_valid at edge N+2.
REQ-037 Lane0 0x3FE0 (1.75), lane1 0x3EE0 (E=125), lane2 0x0000, others 0x3F80 → o_E = 127, lanes 0/1/2 = 4'b0111 / 4'b0001 / 4'b0000.
REQ-038 Lane0 0x3F60 (0.875, E=126), others 1.0 → lane0 = 4'b0011 without BFP_ROUND_EN and 4'b0100 with it; sign test 0xBF80 → 4'b1100.
REQ-039 3 elements of 1.0, then i_flush in the same cycle as the 3rd accept → o_E = 127, lanes 0-2 = 4'b0100, lanes 3-15 = 0.
REQ-040 Hold i_ready = 0 for 5 cycles in OUT → o_valid, o_E and o_M stable and o_ready = 0; the block completes on the first i_ready cycle.
REQ-041 Assert i_reset after 7 accepts → o_valid stays 0; the next 16 accepts form a clean block with no stale lanes.

Source files
------------

// File: rtl/bfp_packer.sv
// Packs up to LANES bf16 elements into one block-floating-point word: a shared exponent plus
// {sign, magnitude} lanes. Define BFP_ROUND_EN for round-half-up alignment instead of truncation.
module bfp_packer #(
    parameter int LANES = 16,
    parameter int MAG_W = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [15:0]                i_data,
    input  logic                       i_flush,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [7:0]                 o_E,
    output logic [LANES*(MAG_W+1)-1:0] o_M
);
    localparam int CNT_W = $clog2(LANES);
    localparam int LW    = MAG_W + 1;

    typedef enum logic [1:0] {S_FILL, S_ALIGN, S_OUT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [7:0]       max_reg, max_next;

    logic                accept;
    logic                last_lane;
    logic                handshake;
    logic [LANES*LW-1:0] m_next;
    logic                unused_data;

    assign o_ready     = (state_reg == S_FILL);
    assign o_valid     = (state_reg == S_OUT);
    assign accept      = i_valid && o_ready;
    assign last_lane   = (count_reg == CNT_W'(LANES - 1));
    assign handshake   = o_valid && i_ready;
    assign unused_data = ^i_data[6-MAG_W:0];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        max_next   = max_reg;
        case (state_reg)
            S_FILL: begin
                if (accept) begin
                    count_next = last_lane ? '0 : count_reg + CNT_W'(1);
                    if (i_data[14:7] > max_reg)
                        max_next = i_data[14:7];
                end
                // A flush on the same cycle as an accept closes the block after that element.
                if (accept && last_lane) begin
                    state_next = S_ALIGN;
                end else if (i_flush && (accept || count_reg != '0)) begin
                    state_next = S_ALIGN;
                    count_next = '0;
                end
            end
            S_ALIGN: state_next = S_OUT;
            S_OUT: begin
                if (i_ready) begin
                    state_next = S_FILL;
                    max_next   = '0;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= S_FILL;
            count_reg <= '0;
            max_reg   <= '0;
            o_E       <= '0;
            o_M       <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            max_reg   <= max_next;
            if (state_reg == S_ALIGN) begin
                o_E <= max_reg;
                o_M <= m_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic             sign_reg;
            logic [7:0]       exp_reg;
            logic [MAG_W-1:0] frac_reg;
            logic [7:0]       shift;
            logic [MAG_W-1:0] mag;

            // Lanes are cleared between blocks so a flushed block reads unfilled lanes as +0.
            always_ff @(posedge i_clk) begin
                if (i_reset || handshake) begin
                    sign_reg <= 1'b0;
                    exp_reg  <= '0;
                    frac_reg <= '0;
                end else if (accept && count_reg == CNT_W'(gi)) begin
                    sign_reg <= i_data[15];
                    exp_reg  <= i_data[14:7];
                    frac_reg <= i_data[6 -: MAG_W];
                end
            end

`ifdef BFP_ROUND_EN
            logic [MAG_W:0] v_full;
            logic [MAG_W:0] sum;

            always_comb begin
                shift  = max_reg - exp_reg;
                v_full = {1'b1, frac_reg} >> shift;
                sum    = {1'b0, v_full[MAG_W:1]} + {{MAG_W{1'b0}}, v_full[0]};
                mag    = sum[MAG_W] ? '1 : sum[MAG_W-1:0];
                if (exp_reg == '0)
                    mag = '0;
            end
`else
            logic [MAG_W-1:0] v_trunc;
            logic             unused_lsb;

            assign unused_lsb = frac_reg[0];

            always_comb begin
                shift   = max_reg - exp_reg;
                v_trunc = {1'b1, frac_reg[MAG_W-1:1]} >> shift;
                mag     = (exp_reg == '0) ? '0 : v_trunc;
            end
`endif
            assign m_next[gi*LW +: LW] = {sign_reg, mag};
        end
    endgenerate

endmodule

// File: tb/tb_bfp_packer.sv
// Directed bench for bfp_packer: the driver queues hand-computed blocks, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_bfp_packer;
    localparam int LANES = 16;
    localparam int LW    = 4;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_valid;
    logic                  o_ready;
    logic [15:0]           i_data;
    logic                  i_flush;
    logic                  o_valid;
    logic                  i_ready;
    logic [7:0]            o_E;
    logic [LANES*LW-1:0]   o_M;

    always #5 clk = ~clk;

    bfp_packer #(.LANES(LANES), .MAG_W(3)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_E     (o_E),
        .o_M     (o_M)
    );

    typedef struct {
        logic [7:0]          e;
        logic [LANES*LW-1:0] m;
        int                  close_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] blk[LANES];
    logic [3:0]  nib[LANES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented block against the head of the scoreboard.
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_block: got o_E=%h o_M=%h, required no block", o_E, o_M);
            end else begin
                check("o_E", {56'd0, o_E}, {56'd0, sb[0].e});
                check("o_M", o_M, sb[0].m);
                check("o_ready_in_out", {63'd0, o_ready}, 64'd0);
                if (!prev_valid)
                    check("latency", 64'(cyc), 64'(sb[0].close_cyc + 1));
                if (i_ready)
                    void'(sb.pop_front());
            end
        end
        prev_valid = o_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] d, input logic [3:0] nb);
        for (int k = 0; k < LANES; k++) begin
            blk[k] = d;
            nib[k] = nb;
        end
    endtask

    task automatic push_exp(input logic [7:0] e, input int close_cyc);
        exp_t x;
        x.e = e;
        x.close_cyc = close_cyc;
        x.m = '0;
        for (int k = 0; k < LANES; k++)
            x.m[k*LW +: LW] = nib[k];
        sb.push_back(x);
    endtask

    task automatic send(input int n, input bit flush_last, input logic [7:0] e);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = blk[i];
            i_flush = flush_last && (i == n - 1);
            check("o_ready_fill", {63'd0, o_ready}, 64'd1);
            if (i == n - 1 && (flush_last || n == LANES))
                push_exp(e, cyc + 1);
            tick();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
    endtask

    task automatic flush_only(input logic [7:0] e);
        i_flush = 1'b1;
        push_exp(e, cyc + 1);
        tick();
        i_flush = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++)
            tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending blocks, required 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic wait_out();
        for (int t = 0; t < 40 && !o_valid; t++)
            tick();
        check("out_reached", {63'd0, o_valid}, 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_o_valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, "_o_ready"}, {63'd0, o_ready}, 64'd1);
        check({tag, "_o_E"}, {56'd0, o_E}, 64'd0);
        check({tag, "_o_M"}, o_M, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        check_cleared("reset");

        // 16 x 1.0
        fill(16'h3F80, 4'h4);
        send(16, 1'b0, 8'd127);
        wait_drain();

        // 1.75, E=125, zero, rest 1.0
        fill(16'h3F80, 4'h4);
        blk[0] = 16'h3FE0; nib[0] = 4'h7;
        blk[1] = 16'h3EE0;
`ifdef BFP_ROUND_EN
        nib[1] = 4'h2;
`else
        nib[1] = 4'h1;
`endif
        blk[2] = 16'h0000; nib[2] = 4'h0;
        send(16, 1'b0, 8'd127);
        wait_drain();

        // 0.875 in lane 0
        fill(16'h3F80, 4'h4);
        blk[0] = 16'h3F60;
`ifdef BFP_ROUND_EN
        nib[0] = 4'h4;
`else
        nib[0] = 4'h3;
`endif
        send(16, 1'b0, 8'd127);
        wait_drain();

        // -1.0 in lane 0
        fill(16'h3F80, 4'h4);
        blk[0] = 16'hBF80; nib[0] = 4'hC;
        send(16, 1'b0, 8'd127);
        wait_drain();

        // flush together with the 3rd accept
        fill(16'h3F80, 4'h0);
        nib[0] = 4'h4; nib[1] = 4'h4; nib[2] = 4'h4;
        send(3, 1'b1, 8'd127);
        wait_drain();

        // Inf exponent and a negative zero
        fill(16'h3F80, 4'h0);
        blk[0] = 16'h7F80; nib[0] = 4'h4;
        blk[1] = 16'h8000; nib[1] = 4'h8;
        send(16, 1'b0, 8'd255);
        wait_drain();

        // backpressure: 5 stalled cycles with valid/flush noise, then release
        fill(16'h4000, 4'h4);
        blk[5] = 16'h3F80; nib[5] = 4'h2;
        i_ready = 1'b0;
        send(16, 1'b0, 8'd128);
        wait_out();
        for (int s = 0; s < 5; s++) begin
            i_valid = 1'b1;
            i_flush = 1'b1;
            i_data  = 16'h4000;
            tick();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        tick();
        check("release_o_valid", {63'd0, o_valid}, 64'd0);
        check("release_o_ready", {63'd0, o_ready}, 64'd1);
        check("release_pending", 64'(sb.size()), 64'd0);

        // flush with an empty block is ignored
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("empty_flush_o_ready", {63'd0, o_ready}, 64'd1);
        repeat (3) tick();

        // reset while a block waits in OUT discards it
        fill(16'hC000, 4'hC);
        i_ready = 1'b0;
        send(16, 1'b0, 8'd128);
        wait_out();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        void'(sb.pop_back());
        check_cleared("reset_out");
        i_ready = 1'b1;
        repeat (3) tick();

        // reset after 7 accepts, then a flushed 2-element block must show no stale lanes
        fill(16'h4000, 4'h4);
        send(7, 1'b0, 8'd0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_cleared("reset_fill");
        fill(16'h0000, 4'h0);
        blk[0] = 16'h3F80; nib[0] = 4'h2;
        blk[1] = 16'h4040; nib[1] = 4'h6;
        send(2, 1'b0, 8'd0);
        flush_only(8'd128);
        wait_drain();

        // clean full block after the reset
        fill(16'hC000, 4'hC);
        send(16, 1'b0, 8'd128);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
